// File: rtl/prog_rom_pkg.sv
// Shared definitions for the program ROM loader: load FSM states, word geometry and the NOP word.
package prog_rom_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEF_WORD_WIDTH = 24;
  localparam int unsigned DEF_ADDR_BITS  = 8;

  // An all-zero instruction word decodes as NOP.
  localparam logic [DEF_WORD_WIDTH-1:0] NOP_WORD = '0;

  // Load FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // Number of load bytes that make up one instruction word.
  function automatic int unsigned bytes_per_word(input int unsigned word_width);
    return word_width / BYTE_W;
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port, no reset.
module prog_mem_array #(
  parameter int unsigned WORD_WIDTH = 24,
  parameter int unsigned ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port; the output register holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_rom.sv
// Program ROM with a byte-serial loader: assembles MSB-first bytes into words,
// writes them from a base address, tracks a byte checksum and serves CPU fetches
// with one cycle of latency while no load is in progress.
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  ld_start,
  input  logic [ADDR_BITS-1:0]  ld_base,
  input  logic [ADDR_BITS:0]    ld_len,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic [7:0]            ld_csum
);

  localparam int unsigned BPW       = bytes_per_word(WORD_WIDTH);
  localparam int unsigned BCW       = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned LW        = ADDR_BITS + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  ld_state_e             state_q;
  ld_state_e             state_d;
  logic                  start_c;
  logic                  accept_c;
  logic                  wr_en_c;
  logic                  rd_req_c;

  logic [ADDR_BITS-1:0]  addr_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         word_cnt_q;
  logic [BCW-1:0]        byte_cnt_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [7:0]            csum_q;
  logic                  have_q;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Load FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load FSM next state and per-cycle strobes.
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    accept_c = 1'b0;
    wr_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          start_c = 1'b1;
          state_d = (ld_len == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (ld_valid) begin
          accept_c = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wr_en_c = 1'b1;
        state_d = ((word_cnt_q + LW'(1)) == len_q) ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered handshake/status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      ld_ready <= (state_d == ST_RECV);
      ld_busy  <= (state_d == ST_RECV) || (state_d == ST_WRITE);
      ld_done  <= (state_d == ST_DONE);
    end
  end

  // Load datapath: captured parameters, byte/word counters, shift register, checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
    end else begin
      if (start_c) begin
        addr_q     <= ld_base;
        len_q      <= ld_len;
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
        csum_q     <= '0;
      end
      if (accept_c) begin
        shift_q    <= (shift_q << 8) | WORD_WIDTH'(ld_byte);
        csum_q     <= csum_q + ld_byte;
        byte_cnt_q <= (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BCW'(1);
      end
      if (wr_en_c) begin
        addr_q     <= addr_q + ADDR_BITS'(1);
        word_cnt_q <= word_cnt_q + LW'(1);
      end
    end
  end

  assign ld_csum = csum_q;

  // Fetches are blocked while a load owns the memory.
  assign rd_req_c = rd_en && !ld_busy;

  // Read-valid flag and a marker that the read register has been loaded since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      have_q   <= 1'b0;
    end else begin
      rd_valid <= rd_req_c;
      if (rd_req_c) begin
        have_q <= 1'b1;
      end
    end
  end

  // The storage read register has no reset, so present NOP until the first fetch.
  assign rd_data = have_q ? mem_rdata : WORD_WIDTH'(NOP_WORD);

  prog_mem_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (addr_q),
    .wdata (shift_q),
    .re    (rd_req_c),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom (WORD_WIDTH=24, ADDR_BITS=8).
module tb_prog_rom;

  localparam int unsigned WW = 24;
  localparam int unsigned AB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          ld_start;
  logic [AB-1:0] ld_base;
  logic [AB:0]   ld_len;
  logic [7:0]    ld_byte;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [7:0]    ld_csum;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  prog_rom #(.WORD_WIDTH(WW), .ADDR_BITS(AB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_byte  (ld_byte),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_csum  (ld_csum)
  );

  always #5 clk = ~clk;

  // Free-running pulse counters; tests compare deltas.
  always @(posedge clk) begin
    if (ld_done) done_cnt = done_cnt + 1;
    if (ld_busy) busy_cnt = busy_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AB-1:0] base, input logic [AB:0] len);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    while (!ld_ready && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_byte_ready: ld_ready=%b required 1", ld_ready);
    end else begin
      ld_byte  = b;
      ld_valid = 1'b1;
      tick();
      ld_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [AB-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({rd_data, rd_valid, ld_ready, ld_busy, ld_done, ld_csum} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rd_data=%h rd_valid=%b ready=%b busy=%b done=%b csum=%h required all 0",
               rd_data, rd_valid, ld_ready, ld_busy, ld_done, ld_csum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    int d0 = done_cnt;
    start_load(8'h10, 9'd2);
    total++;
    if (ld_busy !== 1'b1 || ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_recv_entry: busy=%b ready=%b required 1 1", ld_busy, ld_ready);
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    total++;
    if (ld_ready !== 1'b0 || ld_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_write_state: ready=%b busy=%b required 0 1", ld_ready, ld_busy);
    end
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    tick();
    total++;
    if (ld_done !== 1'b1 || ld_busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_state: done=%b busy=%b required 1 0", ld_done, ld_busy);
    end
    tick();
    tick();
    total++;
    if (done_cnt - d0 != 1 || ld_done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulses: pulses=%0d done=%b required 1 0", done_cnt - d0, ld_done);
    end
    total++;
    if (ld_csum !== 8'h15) begin
      bad++;
      $display("FAIL basic_csum: got %h required 15", ld_csum);
    end
    do_read(8'h11);
    total++;
    if (rd_data !== 24'h040506 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_read_11: data=%h valid=%b required 040506 1", rd_data, rd_valid);
    end
    do_read(8'h10);
    total++;
    if (rd_data !== 24'h010203 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_read_10: data=%h valid=%b required 010203 1", rd_data, rd_valid);
    end
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL read_idle_hold: data=%h valid=%b required 010203 0", rd_data, rd_valid);
    end
  endtask

  task automatic test_read_during_wrap_load();
    start_load(8'hFF, 9'd2);
    rd_en   = 1'b1;
    rd_addr = 8'h11;
    send_byte(8'hAA);
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL busy_read_block1: data=%h valid=%b required 010203 0", rd_data, rd_valid);
    end
    send_byte(8'hBB); send_byte(8'hCC);
    tick();
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL busy_read_block2: data=%h valid=%b required 010203 0", rd_data, rd_valid);
    end
    rd_en = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    tick(); tick(); tick();
    total++;
    if (ld_csum !== 8'h97) begin
      bad++;
      $display("FAIL wrap_csum: got %h required 97", ld_csum);
    end
    do_read(8'hFF);
    total++;
    if (rd_data !== 24'hAABBCC) begin
      bad++;
      $display("FAIL wrap_read_ff: got %h required aabbcc", rd_data);
    end
    do_read(8'h00);
    total++;
    if (rd_data !== 24'h112233) begin
      bad++;
      $display("FAIL wrap_read_00: got %h required 112233", rd_data);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    int b0 = busy_cnt;
    start_load(8'h10, 9'd0);
    total++;
    if (ld_done !== 1'b1 || ld_busy !== 1'b0 || ld_csum !== 8'h00) begin
      bad++;
      $display("FAIL zero_len_done: done=%b busy=%b csum=%h required 1 0 00", ld_done, ld_busy, ld_csum);
    end
    tick();
    tick();
    total++;
    if (ld_done !== 1'b0 || done_cnt - d0 != 1 || busy_cnt - b0 != 0) begin
      bad++;
      $display("FAIL zero_len_pulse: done=%b pulses=%0d busy_cycles=%0d required 0 1 0",
               ld_done, done_cnt - d0, busy_cnt - b0);
    end
    do_read(8'h10);
    total++;
    if (rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL zero_len_mem: got %h required 010203", rd_data);
    end
  endtask

  task automatic test_read_at_start();
    rd_en   = 1'b1;
    rd_addr = 8'h11;
    start_load(8'h11, 9'd1);
    rd_en = 1'b0;
    total++;
    if (rd_data !== 24'h040506 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL start_cycle_read: data=%h valid=%b required 040506 1", rd_data, rd_valid);
    end
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    tick(); tick(); tick();
    do_read(8'h11);
    total++;
    if (rd_data !== 24'h778899 || ld_csum !== 8'h98) begin
      bad++;
      $display("FAIL reload_11: data=%h csum=%h required 778899 98", rd_data, ld_csum);
    end
  endtask

  task automatic test_reset_midload();
    int d0;
    start_load(8'h10, 9'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    total++;
    if (ld_busy !== 1'b1) begin
      bad++;
      $display("FAIL midload_busy: got %b required 1", ld_busy);
    end
    rst = 1'b1;
    #1;
    total++;
    if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || ld_csum !== 8'h00 || rd_data !== '0) begin
      bad++;
      $display("FAIL midload_async_rst: busy=%b ready=%b csum=%h rd_data=%h required 0 0 00 0",
               ld_busy, ld_ready, ld_csum, rd_data);
    end
    tick();
    rst = 1'b0;
    tick();
    ld_valid = 1'b1;
    ld_byte  = 8'h5A;
    tick();
    ld_valid = 1'b0;
    total++;
    if (ld_ready !== 1'b0 || ld_busy !== 1'b0 || ld_csum !== 8'h00) begin
      bad++;
      $display("FAIL post_rst_idle: ready=%b busy=%b csum=%h required 0 0 00", ld_ready, ld_busy, ld_csum);
    end
    d0 = done_cnt;
    start_load(8'h40, 9'd0);
    total++;
    if (ld_done !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_fsm_idle: done=%b required 1", ld_done);
    end
    tick();
    do_read(8'h10);
    total++;
    if (rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL post_rst_mem10: got %h required 010203", rd_data);
    end
    do_read(8'h11);
    total++;
    if (rd_data !== 24'h778899 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL post_rst_mem11: data=%h pulses=%0d required 778899 1", rd_data, done_cnt - d0);
    end
  endtask

  task automatic test_toggle_restart();
    logic [7:0] bytes [6];
    int d0;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    bytes[3] = 8'h04; bytes[4] = 8'h05; bytes[5] = 8'h06;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    tick(); tick();
    ld_valid = 1'b0;
    d0 = done_cnt;
    start_load(8'h10, 9'd2);
    for (int i = 0; i < 6; i++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      send_byte(bytes[i]);
      if (i == 1) begin
        start_load(8'h50, 9'd1);
      end
      if (i == 2) begin
        total++;
        if (ld_ready !== 1'b0) begin
          bad++;
          $display("FAIL toggle_write_ready: got %b required 0", ld_ready);
        end
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        tick();
        ld_valid = 1'b0;
      end
    end
    tick(); tick(); tick();
    total++;
    if (ld_csum !== 8'h15 || done_cnt - d0 != 1 || ld_busy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_result: csum=%h pulses=%0d busy=%b required 15 1 0", ld_csum, done_cnt - d0, ld_busy);
    end
    do_read(8'h10);
    total++;
    if (rd_data !== 24'h010203) begin
      bad++;
      $display("FAIL toggle_mem10: got %h required 010203", rd_data);
    end
    do_read(8'h11);
    total++;
    if (rd_data !== 24'h040506) begin
      bad++;
      $display("FAIL toggle_mem11: got %h required 040506", rd_data);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_len   = '0;
    ld_byte  = '0;
    ld_valid = 1'b0;
    test_reset();
    test_load_basic();
    test_read_during_wrap_load();
    test_zero_len();
    test_read_at_start();
    test_reset_midload();
    test_toggle_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
